test1_decoder: RTL and testbench
================================

TEST1_DECODER -- requirements
Module: test1

Interface
REQ-001 The module SHALL have the port `clk`, an input of width 1 that is the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port `rst`, an input of width 1; reset is asynchronous and active-high.
REQ-003 The module SHALL have the port `INn`, an input of width 72 carrying the received SECDED (72,64) codeword, sampled on every rising clk edge.
REQ-004 The module SHALL have the port `real_data`, an output of width 64 carrying the decoded, corrected data word; it is registered.
REQ-005 The module SHALL have the port `ERRr`, an output of width 1 that flags an uncorrectable error; it is registered and aligned with real_data.

Function
REQ-006 Codeword bit mapping SHALL be as follows:
- Hamming position p (1..71) is carried on INn[p-1].
- Check bits are at positions 1, 2, 4, 8, 16, 32 and 64.
- Data bits d[0..63] fill the remaining positions in ascending order: d[0] at position 3, d[63] at position 71.
- INn[71] is the overall parity bit; the valid codeword has even parity over INn[71:0].
REQ-007 Syndrome bit s[i] (i=0..6) SHALL be the XOR of INn[p-1] over all p in 1..71 whose binary index has bit i set. P SHALL be the XOR of INn[71:0].
REQ-008 The decode outcome SHALL follow from s and P:
- s=0, P=0: no error; data is passed through; ERRr=0.
- s=0, P=1: the error is in the overall parity bit; data is passed through; ERRr=0.
- s in 1..71, P=1: single error; the bit at position s is inverted before data extraction; ERRr=0.
- s in 72..127, P=1: invalid position; raw data is output; ERRr=1.
- s≠0, P=0: double error; raw, uncorrected data is output; ERRr=1.
REQ-009 Latency SHALL be one clock: the result for INn present at rising edge N appears on the outputs immediately after edge N and holds until edge N+1.
REQ-010 The module SHALL have no handshake or enable; a new word is decoded every cycle and there is no internal state beyond the output registers.
REQ-011 Decode logic SHALL be purely combinational between INn and the output registers; no multicycle paths.

Reset
REQ-012 While rst=1, real_data SHALL be 64'h0 and ERRr SHALL be 0; assertion takes effect immediately, independent of clk.
REQ-013 On the first rising edge after rst deasserts, the module SHALL register the decode of the current INn.
REQ-014 Reset asserted mid-stream SHALL discard the pending result; there is no recovery of pre-reset data.

Configuration
REQ-015 The macro TEST1_CORRECT_EN SHALL select the correction behaviour:
- Defined: behaviour is as in REQ-008.
- Undefined: no correction is performed; real_data is always the raw extracted data; ERRr=1 for every case except s=0 (with P=0 or P=1).

Verification
REQ-016 Clean word: INn = 72'h80_0000_0000_0000_0007 (d=1) -> next cycle real_data = 64'h1, ERRr = 0.
REQ-017 Check-bit error: INn = 72'h1 -> real_data = 0, ERRr = 0 (s=1, P=1).
REQ-018 Data error: INn = 72'h4 (position 3 flipped), with TEST1_CORRECT_EN defined -> real_data = 0, ERRr = 0. With TEST1_CORRECT_EN undefined -> real_data = 64'h1, ERRr = 1.
REQ-019 Double error: INn = 72'h3 -> s=3, P=0 -> real_data = 0, ERRr = 1.
REQ-020 Parity-only error: INn = 72'h80_0000_0000_0000_0000 -> real_data = 0, ERRr = 0.
REQ-021 Asynchronous reset: drive valid words to produce nonzero outputs, then assert rst between edges -> real_data = 0 and ERRr = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/test1_decoder.sv
// SECDED (72,64) decoder with one-cycle registered output.
// Define TEST1_CORRECT_EN to enable single-error correction.
module test1_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [71:0] INn,
    output logic [63:0] real_data,
    output logic        ERRr
);

    typedef logic [63:0][6:0]  idx_tab_t;
    typedef logic [6:0][71:0]  mask_tab_t;

    // Codeword bit index of each data bit (non-power-of-two positions, ascending).
    function automatic idx_tab_t build_data_idx();
        idx_tab_t tab;
        int       k;
        tab = '0;
        k   = 0;
        for (int p = 1; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                tab[6'(k)] = 7'(p - 1);
                k++;
            end
        end
        return tab;
    endfunction

    // Syndrome bit i covers every position whose index has bit i set.
    function automatic mask_tab_t build_syn_mask();
        mask_tab_t tab;
        tab = '0;
        for (int i = 0; i < 7; i++) begin
            for (int p = 1; p < 72; p++) begin
                tab[3'(i)][7'(p - 1)] = 1'((p >> i) & 1);
            end
        end
        return tab;
    endfunction

    localparam idx_tab_t  DataIdx = build_data_idx();
    localparam mask_tab_t SynMask = build_syn_mask();

    logic [6:0]  syn;
    logic [71:0] flip;
    logic [71:0] cw;
    logic [63:0] real_data_d, real_data_q;
    logic        err_d, err_q;

`ifdef TEST1_CORRECT_EN
    logic par;
    logic single;
`endif

    always_comb begin
        syn = '0;
        for (int i = 0; i < 7; i++) begin
            syn[3'(i)] = ^(INn & SynMask[3'(i)]);
        end
        flip = '0;
`ifdef TEST1_CORRECT_EN
        par    = ^INn;
        single = par && (syn != 7'd0) && (syn <= 7'd71);
        if (single) begin
            flip = 72'(1) << (syn - 7'd1);
        end
        // s=0 with P=1 is a parity-bit hit: data is intact.
        err_d = (syn != 7'd0) && !single;
`else
        err_d = (syn != 7'd0);
`endif
        cw = INn ^ flip;
        real_data_d = '0;
        for (int j = 0; j < 64; j++) begin
            real_data_d[6'(j)] = cw[DataIdx[6'(j)]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            real_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            real_data_q <= real_data_d;
            err_q       <= err_d;
        end
    end

    assign real_data = real_data_q;
    assign ERRr      = err_q;

endmodule

// File: tb/tb_test1_decoder.sv
// Self-checking bench for test1_decoder: vector table, random single/double
// error sweep, and asynchronous reset sequences.
module tb_test1_decoder;

    logic        clk;
    logic        rst;
    logic [71:0] INn;
    logic [63:0] real_data;
    logic        ERRr;

    int n_vec  = 0;
    int n_fail = 0;

    test1_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .INn       (INn),
        .real_data (real_data),
        .ERRr      (ERRr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef TEST1_CORRECT_EN
    localparam bit Corr = 1'b1;
`else
    localparam bit Corr = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [71:0] in;
        logic [63:0] d;
        logic        e;
    } vec_t;

    typedef struct {
        string       name;
        logic [63:0] d;
        logic        e;
    } exp_t;

    exp_t sb[$];

    function automatic logic [71:0] encode(input logic [63:0] d);
        logic [71:0] cw;
        logic        x;
        int          k;
        cw = '0;
        k  = 0;
        for (int p = 1; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[7'(p - 1)] = d[6'(k)];
                k++;
            end
        end
        for (int i = 0; i < 7; i++) begin
            x = 1'b0;
            for (int p = 1; p < 72; p++) begin
                if (((p >> i) & 1) != 0) x = x ^ cw[7'(p - 1)];
            end
            cw[7'((1 << i) - 1)] = x;
        end
        cw[71] = ^cw[70:0];
        return cw;
    endfunction

    // Data bit carried by codeword bit b, or -1 for check/parity bits.
    function automatic int data_bit_of(input int b);
        int k;
        k = 0;
        for (int p = 1; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (p - 1 == b) return k;
                k++;
            end
        end
        return -1;
    endfunction

    task automatic cmp(input string name, input logic [63:0] ed, input logic ee);
        n_vec++;
        if (real_data !== ed || ERRr !== ee) begin
            n_fail++;
            $display("FAIL %s: real_data=%h ERRr=%b, expected real_data=%h ERRr=%b",
                     name, real_data, ERRr, ed, ee);
        end
    endtask

    task automatic check_out();
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            cmp(x.name, x.d, x.e);
        end
    endtask

    // Called on a falling edge; returns on the next falling edge.
    task automatic step(input string name, input logic [71:0] v,
                        input logic [63:0] d, input logic e);
        exp_t x;
        check_out();
        INn = v;
        x.name = name;
        x.d    = d;
        x.e    = e;
        sb.push_back(x);
        @(negedge clk);
    endtask

    vec_t        tbl[$];
    vec_t        v;
    logic [63:0] dw;
    logic [63:0] raw;
    logic [71:0] cw;
    logic        e;
    int          nflip;
    int          b1;
    int          b2;
    int          k;

    initial begin
        rst = 1'b1;
        INn = 72'h80_0000_0000_0000_0007;
        #3;
        cmp("reset_async", 64'h0, 1'b0);
        @(negedge clk);
        cmp("reset_held_edge", 64'h0, 1'b0);

        dw = 64'hDEAD_BEEF_0123_4567;
        tbl.push_back('{"clean_d1", 72'h80_0000_0000_0000_0007, 64'h1, 1'b0});
        tbl.push_back('{"zero", 72'h0, 64'h0, 1'b0});
        tbl.push_back('{"check_bit", 72'h1, 64'h0, !Corr});
        tbl.push_back('{"data_pos3", 72'h4, Corr ? 64'h0 : 64'h1, !Corr});
        tbl.push_back('{"double", 72'h3, 64'h0, 1'b1});
        tbl.push_back('{"parity_only", 72'h80_0000_0000_0000_0000, 64'h0, 1'b0});
        tbl.push_back('{"invalid_s72", 72'h00_8000_0000_0000_0101, 64'h10, 1'b1});
        tbl.push_back('{"all_ones", encode(~64'h0), ~64'h0, 1'b0});
        tbl.push_back('{"clean_mix", encode(dw), dw, 1'b0});
        tbl.push_back('{"flip_d63", encode(dw) ^ (72'h1 << 70),
                        Corr ? dw : dw ^ (64'h1 << 63), !Corr});
        tbl.push_back('{"flip_chk64", encode(dw) ^ (72'h1 << 63), dw, !Corr});
        tbl.push_back('{"flip_par", encode(dw) ^ (72'h1 << 71), dw, 1'b0});

        // rst released here: the first edge registers the first table entry.
        rst = 1'b0;
        foreach (tbl[i]) begin
            v = tbl[i];
            step(v.name, v.in, v.d, v.e);
        end

        for (int n = 0; n < 60; n++) begin
            dw    = {$urandom, $urandom};
            nflip = $urandom_range(0, 2);
            b1    = $urandom_range(0, 71);
            b2    = (b1 + $urandom_range(1, 71)) % 72;
            cw    = encode(dw);
            raw   = dw;
            if (nflip >= 1) begin
                cw[7'(b1)] = ~cw[7'(b1)];
                k = data_bit_of(b1);
                if (k >= 0) raw[6'(k)] = ~raw[6'(k)];
            end
            if (nflip == 2) begin
                cw[7'(b2)] = ~cw[7'(b2)];
                k = data_bit_of(b2);
                if (k >= 0) raw[6'(k)] = ~raw[6'(k)];
            end
            if (nflip == 0) begin
                e = 1'b0;
                raw = dw;
            end else if (nflip == 1) begin
                e = Corr ? 1'b0 : (b1 != 71);
                if (Corr) raw = dw;
            end else begin
                e = 1'b1;
            end
            step($sformatf("rand%0d_f%0d", n, nflip), cw, raw, e);
        end
        check_out();

        // Nonzero output, then reset between edges with a new word pending.
        dw = 64'hA5A5_0F0F_1234_8000;
        step("pre_reset", encode(dw), dw, 1'b0);
        check_out();
        INn = encode(~dw);
        #2 rst = 1'b1;
        #1 cmp("reset_mid_async", 64'h0, 1'b0);
        @(negedge clk);
        cmp("reset_discard", 64'h0, 1'b0);
        rst = 1'b0;
        step("after_reset", 72'h80_0000_0000_0000_0007, 64'h1, 1'b0);
        step("after_reset_dbl", 72'h3, 64'h0, 1'b1);
        check_out();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
